mdu_hilo: RTL and testbench
===========================

# mdu_hilo

Multiply/divide unit with architectural HI/LO registers, sitting in EX alongside the ID/EX segment. It consumes the segment's `ex_mult`/`ex_div`/`ex_mdsign`/`ex_hilowen`/`ex_hiloren` outputs and returns `md_stall`, which freezes the segment while an operation is in flight. It also serves MFHI/MFLO reads and MTHI/MTLO writes. Results commit to HI/LO only when the instruction is allowed to leave EX: no external stall and no flush.

## Interface
- No parameters.
- `clk` — input, 1 — clock.
- `resetn` — input, 1 — reset: one clock; asynchronous, active-low.
- `ex_mult` — input, 1 — MULT/MULTU in EX.
- `ex_div` — input, 1 — DIV/DIVU in EX.
- `ex_mdsign` — input, 1 — 1 = signed operation.
- `ex_A` — input, 32 — GPR[rs]; multiplicand, dividend, or MTHI/MTLO data.
- `ex_B` — input, 32 — GPR[rt]; multiplier or divisor.
- `ex_hilowen` — input, 2 — [1] = MTHI, [0] = MTLO.
- `ex_hiloren` — input, 2 — [1] = MFHI, [0] = MFLO.
- `stall_in` — input, 1 — stall from all sources other than this block.
- `refresh` — input, 1 — pipeline flush; cancels the EX instruction.
- `md_stall` — output, 1 — combinational; holds the ID/EX segment.
- `hilo_rdata` — output, 32 — combinational: HI if `ex_hiloren[1]`, else LO; 0 if `ex_hiloren` is 0.
- `hi` — output, 32 — architectural HI register.
- `lo` — output, 32 — architectural LO register.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - `ex_mult` or `ex_div`, with `!refresh`, starts an operation.
  - `md_stall` = 1 in the start cycle.
  - Mult: full 64-bit product (signed or unsigned) captured into `res_hi`/`res_lo` at the edge; go to DONE.
  - Div: latch absolute operands, quotient and remainder sign flags, and cnt = 0; go to BUSY.
- BUSY (div, or mult with iterative multiplier):
  - One restoring-division step per cycle.
  - `md_stall` = 1.
  - cnt increments; after the edge with cnt = 31, fix signs, load `res_hi` = remainder and `res_lo` = quotient, then go to DONE.
  - `refresh` → IDLE, nothing written.
- DONE:
  - `md_stall` = 0.
  - If `!stall_in && !refresh`: HI ← `res_hi`, LO ← `res_lo`; go to IDLE.
  - If `refresh`: go to IDLE, no write.
  - Else (`stall_in` only): stay in DONE. No restart even though `ex_mult`/`ex_div` is still asserted.
- Signed division:
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Divide by zero (either signedness): LO = 0xFFFFFFFF, HI = `ex_A`.
- MTHI/MTLO:
  - Written from `ex_A` at the edge when `ex_hilowen` bit is set, state is IDLE, and `!stall_in && !refresh`.
  - Both bits set writes both registers.
- Priority: a DONE commit and an MTxx cannot coincide, since they are one instruction each.
- `hilo_rdata` reflects registered HI/LO. Forwarding of a same-cycle commit is not this block's job; the commit precedes any dependent MFxx reaching EX.
- Reset: state IDLE; `hi`, `lo`, `res_hi`, `res_lo`, and cnt all 0; `md_stall` = 0; `hilo_rdata` = 0.
- Asynchronous reset mid-division abandons the operation immediately.

## Timing
- Mult (default): `md_stall` high 1 cycle; DONE the next cycle; HI/LO visible 2 cycles after the mult enters EX if not externally stalled.
- Div: `md_stall` high 33 cycles (1 start + 32 BUSY); HI/LO written at the end of the first unstalled DONE cycle.
- `md_stall` is a function of state and `ex_mult`/`ex_div`/`refresh` only. It never depends on `stall_in`, so there is no combinational loop.
- Back-to-back mult/div: the second starts in the IDLE cycle right after the DONE commit.

## Configuration
- `MDU_MUL_ITER_EN` defined:
  - Multiply uses the BUSY state as a radix-2 shift-add, 32 iterations on magnitudes, sign applied at the end.
  - `md_stall` high 33 cycles, same as divide.
  - No hardware multiplier inferred.
- `MDU_MUL_ITER_EN` undefined: single-cycle `*` product as described in Operation.
- HI/LO results are identical in both builds.

## Test plan
- MULT: `ex_A` = 0xFFFFFFFF, `ex_B` = 2, signed → `md_stall` 1 cycle, then HI = 0xFFFFFFFF, LO = 0xFFFFFFFE. Same operands, MULTU → HI = 1, LO = 0xFFFFFFFE.
- DIV signed −7/2 → `md_stall` exactly 33 cycles; LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100/7 → LO = 0xE, HI = 2.
- DIV by zero, `ex_A` = 0x1234 → LO = 0xFFFFFFFF, HI = 0x1234. Then 0x80000000 / −1 signed → LO = 0x80000000, HI = 0.
- `refresh` pulsed at BUSY cnt = 10 → state IDLE next cycle, `md_stall` drops, HI/LO unchanged. Async `resetn` low mid-div → HI = LO = 0 immediately.
- Div completes while `stall_in` held 5 cycles → stays in DONE, no restart, HI/LO unchanged until `stall_in` falls, then committed once.
- MTHI 0xA5A5A5A5 with `stall_in` = 1 → no write; `stall_in` = 0 → `hi` = 0xA5A5A5A5. `ex_hiloren` = 2'b10 → `hilo_rdata` = 0xA5A5A5A5.

Source files
------------

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with architectural HI/LO; holds the ID/EX segment while an operation runs.
// Optional MDU_MUL_ITER_EN: multiply uses the 32-step BUSY loop instead of a single-cycle multiplier.
module mdu_hilo (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_mult,
  input  logic        ex_div,
  input  logic        ex_mdsign,
  input  logic [31:0] ex_A,
  input  logic [31:0] ex_B,
  input  logic [1:0]  ex_hilowen,
  input  logic [1:0]  ex_hiloren,
  input  logic        stall_in,
  input  logic        refresh,
  output logic        md_stall,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d;

  logic        a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic [32:0] rem_sh;
  logic        no_borrow;
  logic [31:0] step_rem, step_quo;

  assign a_neg = ex_mdsign & ex_A[31];
  assign b_neg = ex_mdsign & ex_B[31];
  assign a_abs = a_neg ? -ex_A : ex_A;
  assign b_abs = b_neg ? -ex_B : ex_B;

  // Restoring step; a zero divisor never borrows, so the quotient fills with ones
  // and the remainder ends up holding the raw dividend.
  assign rem_sh    = {rem_q, quo_q[31]};
  assign no_borrow = rem_sh >= {1'b0, dvs_q};

`ifdef MDU_MUL_ITER_EN
  logic        mul_q, mul_d;
  logic [32:0] mul_add;
  logic [63:0] mul_fix;

  assign mul_add  = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvs_q} : 33'd0);
  assign step_rem = mul_q ? mul_add[32:1] : (no_borrow ? 32'(rem_sh - {1'b0, dvs_q}) : rem_sh[31:0]);
  assign step_quo = mul_q ? {mul_add[0], quo_q[31:1]} : {quo_q[30:0], no_borrow};
  assign mul_fix  = qneg_q ? -{step_rem, step_quo} : {step_rem, step_quo};
`else
  logic [63:0] ext_a, ext_b, product;

  assign ext_a    = {{32{a_neg}}, ex_A};
  assign ext_b    = {{32{b_neg}}, ex_B};
  assign product  = ext_a * ext_b;
  assign step_rem = no_borrow ? 32'(rem_sh - {1'b0, dvs_q}) : rem_sh[31:0];
  assign step_quo = {quo_q[30:0], no_borrow};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    md_stall = 1'b0;
`ifdef MDU_MUL_ITER_EN
    mul_d    = mul_q;
`endif
    case (state_q)
      IDLE: begin
        if ((ex_mult || ex_div) && !refresh) begin
          md_stall = 1'b1;
          cnt_d    = 5'd0;
          rem_d    = 32'd0;
          if (ex_div) begin
            state_d = BUSY;
            if (ex_B == 32'd0) begin
              quo_d  = ex_A;
              dvs_d  = 32'd0;
              qneg_d = 1'b0;
              rneg_d = 1'b0;
            end else begin
              quo_d  = a_abs;
              dvs_d  = b_abs;
              qneg_d = a_neg ^ b_neg;
              rneg_d = a_neg;
            end
`ifdef MDU_MUL_ITER_EN
            mul_d = 1'b0;
          end else begin
            state_d = BUSY;
            quo_d   = b_abs;
            dvs_d   = a_abs;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = 1'b0;
            mul_d   = 1'b1;
          end
`else
          end else begin
            state_d  = DONE;
            res_hi_d = product[63:32];
            res_lo_d = product[31:0];
          end
`endif
        end else if (!stall_in && !refresh) begin
          if (ex_hilowen[1]) hi_d = ex_A;
          if (ex_hilowen[0]) lo_d = ex_A;
        end
      end
      BUSY: begin
        md_stall = 1'b1;
        if (refresh) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
          rem_d = step_rem;
          quo_d = step_quo;
          if (cnt_q == 5'd31) begin
            state_d  = DONE;
            res_hi_d = rneg_q ? -step_rem : step_rem;
            res_lo_d = qneg_q ? -step_quo : step_quo;
`ifdef MDU_MUL_ITER_EN
            if (mul_q) begin
              res_hi_d = mul_fix[63:32];
              res_lo_d = mul_fix[31:0];
            end
`endif
          end
        end
      end
      DONE: begin
        if (refresh) begin
          state_d = IDLE;
        end else if (!stall_in) begin
          state_d = IDLE;
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
`ifdef MDU_MUL_ITER_EN
      mul_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MDU_MUL_ITER_EN
      mul_q    <= mul_d;
`endif
    end
  end

  assign hi         = hi_q;
  assign lo         = lo_q;
  assign hilo_rdata = ex_hiloren[1] ? hi_q : (ex_hiloren[0] ? lo_q : 32'd0);

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed and random MULT/DIV against an arithmetic model,
// plus external stall, flush, asynchronous reset and MTxx/MFxx behaviour.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_mult, ex_div, ex_mdsign;
  logic [31:0] ex_A, ex_B;
  logic [1:0]  ex_hilowen, ex_hiloren;
  logic        stall_in, refresh;
  logic        md_stall;
  logic [31:0] hilo_rdata, hi, lo;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_hi   = 32'd0;
  logic [31:0] exp_lo   = 32'd0;

`ifdef MDU_MUL_ITER_EN
  localparam int MulStall = 33;
`else
  localparam int MulStall = 1;
`endif
  localparam int DivStall = 33;

  always #5 clk = ~clk;

  mdu_hilo dut (
    .clk        (clk),
    .resetn     (resetn),
    .ex_mult    (ex_mult),
    .ex_div     (ex_div),
    .ex_mdsign  (ex_mdsign),
    .ex_A       (ex_A),
    .ex_B       (ex_B),
    .ex_hilowen (ex_hilowen),
    .ex_hiloren (ex_hiloren),
    .stall_in   (stall_in),
    .refresh    (refresh),
    .md_stall   (md_stall),
    .hilo_rdata (hilo_rdata),
    .hi         (hi),
    .lo         (lo)
  );

  // Expected {HI, LO} from plain 64-bit integer arithmetic.
  function automatic logic [63:0] ref_model(input logic is_div, input logic sgn,
                                            input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    if (!is_div) begin
      p = sa * sb;
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Presents an op and counts cycles md_stall is high; returns in the first non-stalled cycle (-1 on timeout).
  task automatic issue_op(input logic is_div, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, output int cyc);
    ex_mult   = !is_div;
    ex_div    = is_div;
    ex_mdsign = sgn;
    ex_A      = a;
    ex_B      = b;
    cyc       = 0;
    #1;
    while (md_stall === 1'b1 && cyc < 100) begin
      cyc++;
      @(posedge clk);
      #1;
    end
    if (cyc >= 100) cyc = -1;
  endtask

  task automatic commit_op();
    stall_in = 1'b0;
    @(posedge clk);
    #1;
    ex_mult = 1'b0;
    ex_div  = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    resetn     = 1'b0;
    ex_mult    = 1'b0;
    ex_div     = 1'b0;
    ex_mdsign  = 1'b0;
    ex_A       = 32'd0;
    ex_B       = 32'd0;
    ex_hilowen = 2'b00;
    ex_hiloren = 2'b11;
    stall_in   = 1'b0;
    refresh    = 1'b0;
    #12;
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
    n_checks++; if (md_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", md_stall); end
    n_checks++; if (hilo_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", hilo_rdata); end
    resetn = 1'b1;
    @(posedge clk);
    #1;
    ex_hiloren = 2'b00;
  endtask

  task automatic test_mult();
    logic [31:0] ta[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] tb[2] = '{32'd2, 32'd2};
    logic        ts[2] = '{1'b1, 1'b0};
    logic [63:0] te[2] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0001_FFFF_FFFE};
    logic [31:0] a, b;
    logic        s;
    logic [63:0] e;
    int          cyc;
    for (int i = 0; i < 14; i++) begin
      if (i < 2) begin
        a = ta[i]; b = tb[i]; s = ts[i]; e = te[i];
      end else begin
        a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
        e = ref_model(1'b0, s, a, b);
      end
      issue_op(1'b0, s, a, b, cyc);
      n_checks++; if (cyc !== MulStall) begin n_fail++; $display("FAIL mult_stall[%0d]: got %0d want %0d", i, cyc, MulStall); end
      n_checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_fail++; $display("FAIL mult_precommit[%0d]: got %h want %h", i, {hi, lo}, {exp_hi, exp_lo}); end
      commit_op();
      n_checks++; if ({hi, lo} !== e) begin n_fail++; $display("FAIL mult_result[%0d] a=%h b=%h s=%b: got %h want %h", i, a, b, s, {hi, lo}, e); end
      exp_hi = e[63:32];
      exp_lo = e[31:0];
    end
  endtask

  task automatic test_div();
    logic [31:0] ta[4] = '{32'hFFFF_FFF9, 32'd100, 32'h0000_1234, 32'h8000_0000};
    logic [31:0] tb[4] = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
    logic        ts[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [63:0] te[4] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0002_0000_000E,
                           64'h0000_1234_FFFF_FFFF, 64'h0000_0000_8000_0000};
    logic [31:0] a, b;
    logic        s;
    logic [63:0] e;
    int          cyc;
    for (int i = 0; i < 14; i++) begin
      if (i < 4) begin
        a = ta[i]; b = tb[i]; s = ts[i]; e = te[i];
      end else begin
        a = $urandom;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0:       b = 32'd0;
          1:       b = 32'($urandom_range(1, 20));
          2:       b = -32'($urandom_range(1, 20));
          default: b = $urandom;
        endcase
        e = ref_model(1'b1, s, a, b);
      end
      issue_op(1'b1, s, a, b, cyc);
      n_checks++; if (cyc !== DivStall) begin n_fail++; $display("FAIL div_stall[%0d]: got %0d want %0d", i, cyc, DivStall); end
      commit_op();
      n_checks++; if ({hi, lo} !== e) begin n_fail++; $display("FAIL div_result[%0d] a=%h b=%h s=%b: got %h want %h", i, a, b, s, {hi, lo}, e); end
      exp_hi = e[63:32];
      exp_lo = e[31:0];
    end
  endtask

  task automatic test_stall_hold();
    logic [63:0] e;
    int          cyc;
    e = ref_model(1'b1, 1'b0, 32'd1000, 32'd3);
    issue_op(1'b1, 1'b0, 32'd1000, 32'd3, cyc);
    n_checks++; if (cyc !== DivStall) begin n_fail++; $display("FAIL hold_div_stall: got %0d want %0d", cyc, DivStall); end
    stall_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      n_checks++; if (md_stall !== 1'b0) begin n_fail++; $display("FAIL hold_no_restart[%0d]: got %b want 0", k, md_stall); end
      n_checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_fail++; $display("FAIL hold_unchanged[%0d]: got %h want %h", k, {hi, lo}, {exp_hi, exp_lo}); end
    end
    commit_op();
    n_checks++; if ({hi, lo} !== e) begin n_fail++; $display("FAIL hold_commit: got %h want %h", {hi, lo}, e); end
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    @(posedge clk);
    #1;
    n_checks++; if (md_stall !== 1'b0) begin n_fail++; $display("FAIL hold_idle_after: got %b want 0", md_stall); end
  endtask

  task automatic test_refresh();
    ex_div    = 1'b1;
    ex_mdsign = 1'b0;
    ex_A      = 32'h0000_FFFF;
    ex_B      = 32'd3;
    #1;
    n_checks++; if (md_stall !== 1'b1) begin n_fail++; $display("FAIL flush_start_stall: got %b want 1", md_stall); end
    repeat (11) @(posedge clk);
    #1;
    refresh = 1'b1;
    ex_div  = 1'b0;
    #1;
    n_checks++; if (md_stall !== 1'b1) begin n_fail++; $display("FAIL flush_busy_stall: got %b want 1", md_stall); end
    @(posedge clk);
    #1;
    refresh = 1'b0;
    #1;
    n_checks++; if (md_stall !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got %b want 0", md_stall); end
    repeat (40) @(posedge clk);
    #1;
    n_checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_fail++; $display("FAIL flush_no_write: got %h want %h", {hi, lo}, {exp_hi, exp_lo}); end
  endtask

  task automatic test_mt();
    stall_in   = 1'b1;
    ex_hilowen = 2'b10;
    ex_A       = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    n_checks++; if (hi !== exp_hi) begin n_fail++; $display("FAIL mthi_stalled: got %h want %h", hi, exp_hi); end
    stall_in = 1'b0;
    @(posedge clk);
    #1;
    ex_hilowen = 2'b00;
    exp_hi     = 32'hA5A5_A5A5;
    n_checks++; if (hi !== exp_hi) begin n_fail++; $display("FAIL mthi_write: got %h want %h", hi, exp_hi); end
    ex_hiloren = 2'b10;
    #1;
    n_checks++; if (hilo_rdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL mfhi_read: got %h want a5a5a5a5", hilo_rdata); end
    ex_hilowen = 2'b01;
    ex_A       = 32'h1357_9BDF;
    refresh    = 1'b1;
    @(posedge clk);
    #1;
    refresh = 1'b0;
    n_checks++; if (lo !== exp_lo) begin n_fail++; $display("FAIL mtlo_flushed: got %h want %h", lo, exp_lo); end
    ex_hilowen = 2'b11;
    ex_A       = 32'h5A5A_0000;
    @(posedge clk);
    #1;
    ex_hilowen = 2'b00;
    exp_hi     = 32'h5A5A_0000;
    exp_lo     = 32'h5A5A_0000;
    n_checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin n_fail++; $display("FAIL mt_both: got %h want %h", {hi, lo}, {exp_hi, exp_lo}); end
    ex_A       = 32'h0BAD_F00D;
    ex_hilowen = 2'b01;
    @(posedge clk);
    #1;
    ex_hilowen = 2'b00;
    exp_lo     = 32'h0BAD_F00D;
    ex_hiloren = 2'b01;
    #1;
    n_checks++; if (hilo_rdata !== exp_lo) begin n_fail++; $display("FAIL mflo_read: got %h want %h", hilo_rdata, exp_lo); end
    ex_hiloren = 2'b11;
    #1;
    n_checks++; if (hilo_rdata !== exp_hi) begin n_fail++; $display("FAIL mf_both_read: got %h want %h", hilo_rdata, exp_hi); end
    ex_hiloren = 2'b00;
    #1;
    n_checks++; if (hilo_rdata !== 32'd0) begin n_fail++; $display("FAIL mf_none_read: got %h want 0", hilo_rdata); end
  endtask

  task automatic test_async_reset();
    logic [63:0] e;
    int          cyc;
    ex_div    = 1'b1;
    ex_mdsign = 1'b0;
    ex_A      = 32'd12345;
    ex_B      = 32'd7;
    repeat (6) @(posedge clk);
    #3;
    resetn = 1'b0;
    ex_div = 1'b0;
    #1;
    n_checks++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL arst_hilo: got %h want 0", {hi, lo}); end
    n_checks++; if (md_stall !== 1'b0) begin n_fail++; $display("FAIL arst_stall: got %b want 0", md_stall); end
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    @(posedge clk);
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    e = ref_model(1'b0, 1'b1, 32'hFFFF_FFF0, 32'd16);
    issue_op(1'b0, 1'b1, 32'hFFFF_FFF0, 32'd16, cyc);
    n_checks++; if (cyc !== MulStall) begin n_fail++; $display("FAIL arst_recover_stall: got %0d want %0d", cyc, MulStall); end
    commit_op();
    n_checks++; if ({hi, lo} !== e) begin n_fail++; $display("FAIL arst_recover_result: got %h want %h", {hi, lo}, e); end
    exp_hi = e[63:32];
    exp_lo = e[31:0];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_stall_hold();
    test_refresh();
    test_mt();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
